// File: rtl/fetch_decode_queue.sv
// Elastic Fetch->Decode buffer: DEPTH-entry circular queue of {PC, PC+4, Instr}.
// Decode sees a NOP bubble whenever the queue is empty.
module fetch_decode_queue #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int DEPTH = 2,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       ValidF,
    output logic                       ReadyF,
    input  logic [XLEN-1:0]            PCF,
    input  logic [XLEN-1:0]            PCPlus4F,
    input  logic [ILEN-1:0]            InstrF,
    output logic                       ValidD,
    input  logic                       ReadyD,
    output logic [XLEN-1:0]            PCD,
    output logic [XLEN-1:0]            PCPlus4D,
    output logic [ILEN-1:0]            InstrD,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] pc4_mem [DEPTH];
    logic [ILEN-1:0] ins_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Readiness depends only on registered count, never on ReadyD.
    assign ReadyF = (count < CW'(DEPTH));
    assign ValidD = (count != '0);
    assign push   = ValidF & ReadyF;
    assign pop    = ValidD & ReadyD;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; stale slots are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= PCF;
            pc4_mem[wr_ptr] <= PCPlus4F;
            ins_mem[wr_ptr] <= InstrF;
        end
    end

    always_comb begin
        PCD      = '0;
        PCPlus4D = '0;
        InstrD   = NOP_INSTR;
        if (ValidD) begin
            PCD      = pc_mem[rd_ptr];
            PCPlus4D = pc4_mem[rd_ptr];
            InstrD   = ins_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= CW'(DEPTH));
            assert (!(push && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed and scoreboarded checks for fetch_decode_queue (DEPTH = 2).
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_fetch_decode_queue;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ValidF = 1'b0;
    logic        ReadyF;
    logic [31:0] PCF = '0;
    logic [31:0] PCPlus4F = '0;
    logic [31:0] InstrF = '0;
    logic        ValidD;
    logic        ReadyD = 1'b0;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [31:0] InstrD;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_decode_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .ValidF(ValidF),
        .ReadyF(ReadyF),
        .PCF(PCF),
        .PCPlus4F(PCPlus4F),
        .InstrF(InstrF),
        .ValidD(ValidD),
        .ReadyD(ReadyD),
        .PCD(PCD),
        .PCPlus4D(PCPlus4D),
        .InstrD(InstrD),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc);
        ValidF   = v;
        PCF      = pc;
        PCPlus4F = pc + 32'd4;
        InstrF   = 32'h00A00000 | pc;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [1:0] n);
        check({tag, ".valid"}, {31'd0, ValidD}, 32'd1);
        check({tag, ".pc"}, PCD, pc);
        check({tag, ".pc4"}, PCPlus4D, pc + 32'd4);
        check({tag, ".instr"}, InstrD, 32'h00A00000 | pc);
        check({tag, ".count"}, {30'd0, count}, {30'd0, n});
    endtask

    task automatic expect_empty(input string tag);
        check({tag, ".valid"}, {31'd0, ValidD}, 32'd0);
        check({tag, ".readyf"}, {31'd0, ReadyF}, 32'd1);
        check({tag, ".pc"}, PCD, 32'd0);
        check({tag, ".pc4"}, PCPlus4D, 32'd0);
        check({tag, ".instr"}, InstrD, NOP);
        check({tag, ".count"}, {30'd0, count}, 32'd0);
    endtask

    logic [31:0] ref_q[$];
    logic        exp_push;
    logic        exp_pop;
    logic [31:0] pc_seq;

    initial begin
        step();
        expect_empty("reset");
        rst = 1'b0;

        // Single entry passes through one edge later, with no bypass.
        ValidF = 1'b1; PCF = 32'h10; PCPlus4F = 32'h14; InstrF = 32'h00500093; ReadyD = 1'b1;
        #1;
        check("t1.nobypass", InstrD, NOP);
        step();
        check("t1.valid", {31'd0, ValidD}, 32'd1);
        check("t1.instr", InstrD, 32'h00500093);
        check("t1.pc", PCD, 32'h10);
        check("t1.pc4", PCPlus4D, 32'h14);
        check("t1.count1", {30'd0, count}, 32'd1);
        ValidF = 1'b0;
        step();
        expect_empty("t1.drain");

        // Fill while Decode stalls; third offer refused.
        ReadyD = 1'b0;
        offer(1'b1, 32'h10); step();
        expect_head("t2.e1", 32'h10, 2'd1);
        offer(1'b1, 32'h14); step();
        expect_head("t2.e2", 32'h10, 2'd2);
        check("t2.full", {31'd0, ReadyF}, 32'd0);
        offer(1'b1, 32'h18); step();
        expect_head("t2.e3", 32'h10, 2'd2);
        offer(1'b0, 32'h0); ReadyD = 1'b1; step();
        expect_head("t2.pop1", 32'h14, 2'd1);
        step();
        expect_empty("t2.pop2");

        // Full with both sides active: pop only, then push+pop.
        ReadyD = 1'b0;
        offer(1'b1, 32'h20); step();
        offer(1'b1, 32'h24); step();
        offer(1'b1, 32'h28); ReadyD = 1'b1; step();
        expect_head("t3.poponly", 32'h24, 2'd1);
        step();
        expect_head("t3.pushpop", 32'h28, 2'd1);
        offer(1'b0, 32'h0); step();
        expect_empty("t3.drain");

        // Flush wins over concurrent push and pop.
        ReadyD = 1'b0;
        offer(1'b1, 32'h30); step();
        offer(1'b1, 32'h34); step();
        offer(1'b1, 32'h38); ReadyD = 1'b1; flush = 1'b1; step();
        expect_empty("t4.flush");
        flush = 1'b0; offer(1'b0, 32'h0); step();
        expect_empty("t4.after");

        // Reset mid-stream.
        ReadyD = 1'b0;
        offer(1'b1, 32'h40); step();
        expect_head("t5.pre", 32'h40, 2'd1);
        rst = 1'b1; offer(1'b1, 32'h44); ReadyD = 1'b1; step();
        expect_empty("t5.rst");
        rst = 1'b0;

        // Streaming across pointer wrap: 2*DEPTH+1 entries.
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            offer(1'b1, 32'h100 + 32'(i) * 4);
            step();
            expect_head($sformatf("t5.wrap%0d", i), 32'h100 + 32'(i) * 4, 2'd1);
        end
        offer(1'b0, 32'h0); step();
        expect_empty("t5.wrapend");

        // Random traffic against a reference FIFO.
        pc_seq = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            offer($urandom_range(0, 3) != 0, pc_seq);
            ReadyD = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 40) == 0;
            exp_push = ValidF && (ref_q.size() < DEPTH);
            exp_pop = ReadyD && (ref_q.size() != 0);
            check("rnd.readyf", {31'd0, ReadyF}, {31'd0, ref_q.size() < DEPTH});
            step();
            if (flush) begin
                ref_q.delete();
            end else begin
                if (exp_pop) void'(ref_q.pop_front());
                if (exp_push) ref_q.push_back(pc_seq);
            end
            if (exp_push) pc_seq = pc_seq + 32'd4;
            check("rnd.count", {30'd0, count}, ref_q.size());
            if (ref_q.size() != 0) begin
                check("rnd.pc", PCD, ref_q[0]);
                check("rnd.instr", InstrD, 32'h00A00000 | ref_q[0]);
            end else begin
                check("rnd.bubble", InstrD, NOP);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
